// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e : FSM states of load_store_unit
//   F3_*        : funct3 access size/sign encodings
//   MASK_*      : byte-lane masks for each access size (aligned at lane 0)
//   size_mask   : funct3[1:0] -> byte-lane mask
//   misaligned  : true when the low address bits are not a multiple of the size
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return MASK_B;
      2'd1:    return MASK_H;
      2'd2:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] low);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return low[0];
      2'd2:    return |low[1:0];
      default: return |low;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte lane logic for the load/store unit.
//   line       : 8-byte little-endian memory line
//   offset     : byte offset of the access inside the line
//   funct3     : access size/sign
//   wdata      : right-aligned store data
//   load_data  : addressed bytes, sign- or zero-extended to 64 bits
//   store_line : line with the addressed bytes replaced by wdata low bytes
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] line,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_line
);

  logic [63:0] shifted;
  logic [63:0] wdata_sh;
  logic [7:0]  lane_mask;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    load_data = '0;
    shifted   = line >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    load_data = shifted;
      F3_BU:   load_data = {56'd0, shifted[7:0]};
      F3_HU:   load_data = {48'd0, shifted[15:0]};
      F3_WU:   load_data = {32'd0, shifted[31:0]};
      default: load_data = '0;
    endcase
  end

  // Accesses reaching here are aligned, so the shifted mask never spills past lane 7.
  always_comb begin
    lane_mask  = size_mask(funct3[1:0]) << offset;
    wdata_sh   = wdata << {offset, 3'b000};
    store_line = line;
    for (int i = 0; i < 8; i++) begin
      if (lane_mask[i]) store_line[8*i +: 8] = wdata_sh[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the EX/MEM stage and an 8-byte-wide data memory.
// Every access reads the containing line; stores then write back the merged line.
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata : access description
//   resp_valid/rdata/err  : one-cycle completion pulse with load data or fault
//   busy                  : stall to the hazard unit (= !req_ready)
//   Mem_Addr, WriteData, MemWrite, MemRead, ReadData : data memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [63:0] Mem_Addr,
  output logic [63:0] WriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] ReadData
);

  lsu_state_e  state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [2:0]  offset_q;
  logic [63:0] wdata_q;
  logic [63:0] line_q;
  logic        err_q;

  logic        mem_read_q;
  logic        mem_write_q;
  logic [63:0] mem_addr_q;
  logic [63:0] write_data_q;

  logic        fault;
  logic [63:0] align_line;
  logic [63:0] load_data;
  logic [63:0] store_line;

  assign fault = (req_funct3 == F3_BAD)
              || (req_we && req_funct3[2])
              || misaligned(req_funct3[1:0], req_addr[2:0])
              || (|req_addr[63:ADDR_BITS]);

  // During READ the merge works on the live memory line so WriteData can be
  // registered in time; in RESP the load result comes from the captured line.
  assign align_line = (state == READ) ? ReadData : line_q;

  lsu_align u_align (
    .line       (align_line),
    .offset     (offset_q),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_line (store_line)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      offset_q     <= '0;
      wdata_q      <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      write_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            offset_q <= req_addr[2:0];
            wdata_q  <= req_wdata;
            err_q    <= fault;
            if (fault) begin
              state <= RESP;
            end else begin
              state      <= READ;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_addr[63:3], 3'b000};
            end
          end
        end
        READ: begin
          mem_read_q <= 1'b0;
          line_q     <= ReadData;
          if (we_q) begin
            state        <= WRITE;
            mem_write_q  <= 1'b1;
            write_data_q <= store_line;
          end else begin
            state      <= RESP;
            mem_addr_q <= '0;
          end
        end
        WRITE: begin
          state        <= RESP;
          mem_write_q  <= 1'b0;
          write_data_q <= '0;
          mem_addr_q   <= '0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = !req_ready;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? load_data : '0;

  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign Mem_Addr   = mem_addr_q;
  assign WriteData  = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int MEM_BYTES = 64;
  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_FAULT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [63:0] Mem_Addr;
  logic [63:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] ReadData;

  load_store_unit #(.ADDR_BITS(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .Mem_Addr   (Mem_Addr),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .ReadData   (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the DUT.
  logic [7:0] dmem     [MEM_BYTES];
  logic [7:0] init_img [MEM_BYTES];
  logic       init_req;

  always_comb begin
    ReadData = '0;
    for (int i = 0; i < 8; i++) ReadData[8*i +: 8] = dmem[int'(Mem_Addr[5:3]) * 8 + i];
  end

  always @(posedge clk) begin
    if (init_req) begin
      dmem <= init_img;
    end else if (MemWrite) begin
      for (int i = 0; i < 8; i++) dmem[int'(Mem_Addr[5:3]) * 8 + i] <= WriteData[8*i +: 8];
    end
  end

  // Reference memory and expectations owned by the model.
  logic [7:0]  ref_mem [MEM_BYTES];
  int          exp_kind;
  int          exp_lat;
  logic        exp_err;
  logic [63:0] exp_rdata;
  logic [63:0] exp_line;
  logic [63:0] exp_maddr;

  // Compare-side bookkeeping.
  int          checks;
  int          failures;
  bit          mon_en;
  bit          pending;
  bit          active;
  int          k;
  int          resp_k;
  logic [63:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [63:0] addr);
    logic [63:0] size;
    size = 64'd1 << f3[1:0];
    return (f3 == 3'b111) || (we && f3[2]) || ((addr % size) != 0) || (addr >= 64'(MEM_BYTES));
  endfunction

  // Fill exp_* from the access rules; stores update the reference memory.
  task automatic model_expect(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wd);
    int size;
    int a;
    int base;
    logic [63:0] v;
    size      = 1 << f3[1:0];
    a         = int'(addr[5:0]);
    base      = a - (a % 8);
    exp_maddr = {addr[63:3], 3'b000};
    exp_rdata = '0;
    exp_line  = '0;
    exp_err   = 1'b0;
    if (model_fault(we, f3, addr)) begin
      exp_kind = K_FAULT;
      exp_lat  = 1;
      exp_err  = 1'b1;
    end else if (!we) begin
      exp_kind = K_LOAD;
      exp_lat  = 2;
      v = '0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_mem[a + i]) << (8 * i));
      if (!f3[2] && size < 8 && v[8 * size - 1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
      exp_rdata = v;
    end else begin
      exp_kind = K_STORE;
      exp_lat  = 3;
      for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
      for (int i = 0; i < 8; i++) exp_line[8*i +: 8] = ref_mem[base + i];
    end
  endtask

  // Per-cycle compare against the model's latency table.
  task automatic compare();
    logic exp_mr;
    logic exp_mw;
    if (active) begin
      k++;
      exp_mr = (exp_kind != K_FAULT) && (k == 1);
      exp_mw = (exp_kind == K_STORE) && (k == 2);
      check("MemRead", MemRead, exp_mr);
      check("MemWrite", MemWrite, exp_mw);
      check("Mem_Addr", Mem_Addr, (exp_mr || exp_mw) ? exp_maddr : 64'd0);
      check("WriteData", WriteData, exp_mw ? exp_line : 64'd0);
      check("busy", busy, 1);
      check("req_ready", req_ready, 0);
      check("resp_valid", resp_valid, k == exp_lat);
      if (resp_valid && resp_k == 0) resp_k = k;
      if (k == exp_lat) begin
        check("resp_err", resp_err, exp_err);
        check("resp_rdata", resp_rdata, exp_rdata);
        last_rdata = resp_rdata;
        last_err   = resp_err;
        active     = 1'b0;
      end
    end else begin
      check("idle busy", busy, 0);
      check("idle req_ready", req_ready, 1);
      check("idle resp_valid", resp_valid, 0);
      check("idle MemRead", MemRead, 0);
      check("idle MemWrite", MemWrite, 0);
      check("idle Mem_Addr", Mem_Addr, 0);
      check("idle WriteData", WriteData, 0);
      if (pending) begin
        pending = 1'b0;
        active  = 1'b1;
        k       = 0;
        resp_k  = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) compare();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd);
    model_expect(we, f3, addr, wd);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    pending    = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8 && active; i++) tick();
    if (active) begin
      check("response timeout", 64'(k), 64'(exp_lat));
      active = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " resp_valid"}, resp_valid, 0);
    check({tag, " resp_err"}, resp_err, 0);
    check({tag, " resp_rdata"}, resp_rdata, 0);
    check({tag, " MemRead"}, MemRead, 0);
    check({tag, " MemWrite"}, MemWrite, 0);
    check({tag, " Mem_Addr"}, Mem_Addr, 0);
    check({tag, " WriteData"}, WriteData, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    int          r;
    int          mw_cnt;
    int          rv_cnt;
    int          mism;

    checks = 0; failures = 0;
    mon_en = 1'b0; pending = 1'b0; active = 1'b0; k = 0; resp_k = 0;
    last_rdata = '0; last_err = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;

    for (int i = 0; i < MEM_BYTES; i++) init_img[i] = 8'($urandom);
    init_img[0] = 8'h09; init_img[1] = 8'h08; init_img[2] = 8'h07; init_img[3] = 8'h06;
    init_img[4] = 8'h05; init_img[5] = 8'h06; init_img[6] = 8'h07; init_img[7] = 8'h08;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_img[i];
    init_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 init_req = 1'b0;

    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Directed accesses with hand-computed results.
    run_req(1'b0, 3'b011, 64'd0, 64'd0);
    check("ld0 rdata", last_rdata, 64'h0807060506070809);
    check("ld0 err", last_err, 0);
    check("ld0 latency", 64'(resp_k), 2);

    run_req(1'b1, 3'b000, 64'd3, 64'h80);
    check("sb3 latency", 64'(resp_k), 3);
    check("sb3 byte3", dmem[3], 8'h80);
    check("sb3 byte2", dmem[2], 8'h07);
    check("sb3 byte4", dmem[4], 8'h05);

    run_req(1'b0, 3'b011, 64'd0, 64'd0);
    check("ld0 after sb", last_rdata, 64'h0807060580070809);

    run_req(1'b0, 3'b000, 64'd3, 64'd0);
    check("lb3", last_rdata, 64'hFFFFFFFFFFFFFF80);

    run_req(1'b0, 3'b100, 64'd3, 64'd0);
    check("lbu3", last_rdata, 64'h0000000000000080);

    run_req(1'b0, 3'b010, 64'd2, 64'd0);
    check("lw2 err", last_err, 1);
    check("lw2 latency", 64'(resp_k), 1);

    run_req(1'b0, 3'b011, 64'd64, 64'd0);
    check("ld64 err", last_err, 1);
    check("ld64 rdata", last_rdata, 0);

    // Back-to-back: req_valid held high across two loads of address 0.
    mon_en = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'd0; req_wdata = '0;
    req_valid = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      case (c)
        0: check("b2b ready at start", req_ready, 1);
        1: begin check("b2b busy c1", busy, 1); check("b2b MemRead c1", MemRead, 1); end
        2: begin
          check("b2b busy c2", busy, 1);
          check("b2b first resp", resp_valid, 1);
          check("b2b first rdata", resp_rdata, 64'h0807060580070809);
        end
        3: begin check("b2b ready c3", req_ready, 1); check("b2b no early read", MemRead, 0); end
        4: begin check("b2b second read", MemRead, 1); check("b2b busy c4", busy, 1); end
        5: check("b2b second resp", resp_valid, 1);
        default: begin check("b2b idle resp", resp_valid, 0); check("b2b idle busy", busy, 0); end
      endcase
      @(posedge clk);
      #1;
      if (c == 3) req_valid = 1'b0;
    end
    mon_en = 1'b1;

    // Randomized accesses checked by the model every cycle.
    for (int n = 0; n < 250; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      r  = $urandom_range(0, 9);
      if (r == 0)      addr = 64'd64 + 64'($urandom_range(0, 63));
      else if (r == 1) addr = {$urandom, $urandom} | 64'h0000_0100_0000_0000;
      else begin
        addr = 64'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
      end
      run_req(we, f3, addr, wd);
    end

    // Reset during READ of an sd to address 8 aborts it.
    mon_en = 1'b0;
    req_we = 1'b1; req_funct3 = 3'b011; req_addr = 64'd8; req_wdata = {$urandom, $urandom};
    req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort in READ", MemRead, 1);
    reset = 1'b1;
    #1 check_all_zero("abort reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mw_cnt = 0; rv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (MemWrite) mw_cnt++;
      if (resp_valid) rv_cnt++;
    end
    check("abort MemWrite pulses", 64'(mw_cnt), 0);
    check("abort resp pulses", 64'(rv_cnt), 0);
    check_all_zero("abort after");
    mism = 0;
    for (int i = 8; i < 16; i++) if (dmem[i] !== ref_mem[i]) mism++;
    check("abort bytes 8..15", 64'(mism), 0);

    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (dmem[i] !== ref_mem[i]) mism++;
    check("final memory image", 64'(mism), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
